// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the matrix-multiply MIPS core.
// Fetches from a combinational instruction memory, decodes lw/sw/add/mul and
// sequences the register file, ALU, multi-cycle multiplier and data memory.
// Strobes and status outputs are registered from the next-state decode, so
// they line up exactly with the state they belong to.
module mips_multicycle_ctrl #(
    parameter logic [31:0] START_ADDR = 32'd0,
    parameter logic [31:0] END_ADDR   = 32'd360,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [4:0]       rf_raddr_a,
    output logic [4:0]       rf_raddr_b,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [1:0]       wb_sel,
    output logic             alu_src_imm,
    output logic [31:0]      imm_ext,
    output logic             mul_start,
    input  logic             mul_done,
    output logic             dmem_re,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MULW,
        S_MEMRD, S_MEMWR, S_WB, S_HALT, S_ERR
    } state_t;

    typedef enum logic [2:0] {OP_ADD, OP_MUL, OP_LW, OP_SW, OP_ILL} op_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] FN_ADD    = 6'b100000;
    localparam logic [5:0] FN_MUL    = 6'b011000;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_MUL = 2'b10;

    function automatic op_t decode_op(input logic [31:0] ir);
        op_t op;
        op = OP_ILL;
        if (ir[31:26] == OPC_RTYPE) begin
            if (ir[5:0] == FN_ADD)      op = OP_ADD;
            else if (ir[5:0] == FN_MUL) op = OP_MUL;
        end else if (ir[31:26] == OPC_LW) begin
            op = OP_LW;
        end else if (ir[31:26] == OPC_SW) begin
            op = OP_SW;
        end
        return op;
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             rf_we_q, rf_we_d;
    logic [1:0]       wb_sel_q, wb_sel_d;
    logic             alu_src_imm_q, alu_src_imm_d;
    logic             mul_start_q, mul_start_d;
    logic             dmem_re_q, dmem_re_d;
    logic             dmem_we_q, dmem_we_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             error_q, error_d;

    op_t         op_cur;
    op_t         op_nxt;
    logic [31:0] pc_next;
    logic        retire;

    assign op_cur  = decode_op(ir_q);
    assign op_nxt  = decode_op(ir_d);
    assign pc_next = pc_q + 32'd4;

    // Next-state, PC, instruction and retire-count logic.
    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        retire    = 1'b0;

        if (abort && state_q != S_ERR) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_d   = S_FETCH;
                        pc_d      = START_ADDR;
                        retired_d = '0;
                    end
                end
                S_FETCH: begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    case (op_cur)
                        OP_ADD, OP_LW, OP_SW: state_d = S_EXEC;
                        OP_MUL:               state_d = S_MULW;
                        default:              state_d = S_ERR;
                    endcase
                end
                S_EXEC: begin
                    case (op_cur)
                        OP_ADD:  state_d = S_WB;
                        OP_LW:   state_d = S_MEMRD;
                        OP_SW:   state_d = S_MEMWR;
                        default: state_d = S_ERR;
                    endcase
                end
                S_MULW:  if (mul_done)   state_d = S_WB;
                S_MEMRD: if (dmem_ready) state_d = S_WB;
                S_MEMWR: if (dmem_ready) retire  = 1'b1;
                S_WB:    retire = 1'b1;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase

            if (retire) begin
                retired_d = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);
                pc_d      = pc_next;
                state_d   = (pc_next >= END_ADDR) ? S_HALT : S_FETCH;
            end
        end
    end

    // Registered outputs decoded from the state being entered.
    always_comb begin
        rf_we_d       = (state_d == S_WB);
        dmem_re_d     = (state_d == S_MEMRD);
        dmem_we_d     = (state_d == S_MEMWR);
        mul_start_d   = (state_d == S_MULW) && (state_q != S_MULW);
        alu_src_imm_d = (state_d == S_EXEC) && (op_nxt == OP_LW || op_nxt == OP_SW);
        wb_sel_d      = WB_ALU;
        if (state_d == S_WB) begin
            if (op_nxt == OP_MUL)     wb_sel_d = WB_MUL;
            else if (op_nxt == OP_LW) wb_sel_d = WB_MEM;
        end
        busy_d   = !(state_d == S_IDLE || state_d == S_HALT || state_d == S_ERR);
        halted_d = (state_d == S_HALT);
        error_d  = (state_d == S_ERR);
    end

    // State, datapath-control and output registers.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= START_ADDR;
            ir_q          <= '0;
            retired_q     <= '0;
            rf_we_q       <= 1'b0;
            wb_sel_q      <= WB_ALU;
            alu_src_imm_q <= 1'b0;
            mul_start_q   <= 1'b0;
            dmem_re_q     <= 1'b0;
            dmem_we_q     <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            retired_q     <= retired_d;
            rf_we_q       <= rf_we_d;
            wb_sel_q      <= wb_sel_d;
            alu_src_imm_q <= alu_src_imm_d;
            mul_start_q   <= mul_start_d;
            dmem_re_q     <= dmem_re_d;
            dmem_we_q     <= dmem_we_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            error_q       <= error_d;
        end
    end

    assign imem_addr   = pc_q;
    assign rf_raddr_a  = ir_q[20:16];
    assign rf_raddr_b  = (op_cur == OP_SW) ? ir_q[25:21] : ir_q[15:11];
    assign rf_waddr    = ir_q[25:21];
    assign imm_ext     = {{16{ir_q[15]}}, ir_q[15:0]};
    assign rf_we       = rf_we_q;
    assign wb_sel      = wb_sel_q;
    assign alu_src_imm = alu_src_imm_q;
    assign mul_start   = mul_start_q;
    assign dmem_re     = dmem_re_q;
    assign dmem_we     = dmem_we_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign error       = error_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: each directed program pushes its
// expected write-back / store events; a monitor pops them as the DUT presents them.
module tb_mips_multicycle_ctrl;

    localparam logic [31:0] END_A = 32'd8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        alu_src_imm;
    logic [31:0] imm_ext;
    logic        mul_start;
    logic        mul_done = 1'b0;
    logic        dmem_re, dmem_we;
    logic        dmem_ready = 1'b0;
    logic        busy, halted, error;
    logic [15:0] retired;

    mips_multicycle_ctrl #(.START_ADDR(32'd0), .END_ADDR(END_A), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .imm_ext(imm_ext),
        .mul_start(mul_start), .mul_done(mul_done),
        .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .busy(busy), .halted(halted), .error(error), .retired(retired)
    );

    always #5 clk = ~clk;

    // Instruction words used by the directed programs.
    localparam logic [31:0] I_LW   = 32'h8D100200; // lw  r8, 0x200(r16)
    localparam logic [31:0] I_ADD3 = 32'h00611020; // add r3, r1, r2
    localparam logic [31:0] I_ADD4 = 32'h00811020; // add r4, r1, r2
    localparam logic [31:0] I_MUL  = 32'h01C84818; // mul r14, r8, r9
    localparam logic [31:0] I_SW   = 32'hACA6FFF0; // sw  r5, -16(r6)
    localparam logic [31:0] I_BAD  = 32'hFC000000;

    logic [31:0] imem [0:15];
    assign imem_data = imem[imem_addr[5:2]];

    typedef struct {
        logic        is_store;
        logic [1:0]  wb_sel;
        logic [4:0]  waddr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [15:0] ret;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;
    int mem_delay = 0;
    int mul_delay = 0;
    int mem_cnt = 0;
    int mcnt = 0;
    int rf_we_cnt = 0;
    int dmem_we_cnt = 0;
    int mul_start_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input logic is_store, input logic [1:0] ws, input logic [4:0] wa,
                           input logic [4:0] ra, input logic [4:0] rb, input logic [31:0] imm,
                           input logic [31:0] pc, input logic [15:0] ret, input int c);
        exp_t e;
        e.is_store = is_store; e.wb_sel = ws; e.waddr = wa; e.ra = ra; e.rb = rb;
        e.imm = imm; e.pc = pc; e.ret = ret; e.cyc = c;
        sb_q.push_back(e);
    endtask

    always @(posedge clk) cyc++;

    // Memory and multiplier responders with programmable latency.
    always begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            mem_cnt = 0; mcnt = 0; dmem_ready = 1'b0; mul_done = 1'b0;
        end else begin
            if (dmem_re || dmem_we) begin
                mem_cnt++;
                dmem_ready = (mem_cnt > mem_delay);
            end else begin
                mem_cnt = 0;
                dmem_ready = 1'b0;
            end
            if (mul_start)                  mcnt = 1;
            else if (mcnt != 0 && !mul_done) mcnt++;
            else                            mcnt = 0;
            mul_done = (mcnt != 0) && (mcnt > mul_delay);
        end
    end

    // Monitor: pops the scoreboard on every write-back or completed store.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rf_we)     rf_we_cnt++;
            if (dmem_we)   dmem_we_cnt++;
            if (mul_start) mul_start_cnt++;
            check("we_exclusive", {31'd0, rf_we & dmem_we}, 32'd0);
            if (rf_we || (dmem_we && dmem_ready)) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_unexpected: event at cycle %0d with empty queue", cyc - base + 1);
                end else begin
                    e = sb_q.pop_front();
                    check("ev_kind", {30'd0, dmem_we && dmem_ready, rf_we},
                          e.is_store ? 32'd2 : 32'd1);
                    check("ev_cycle", cyc - base + 1, e.cyc);
                    check("ev_pc", imem_addr, e.pc);
                    check("ev_retired", {16'd0, retired}, {16'd0, e.ret});
                    check("ev_raddr_a", {27'd0, rf_raddr_a}, {27'd0, e.ra});
                    check("ev_raddr_b", {27'd0, rf_raddr_b}, {27'd0, e.rb});
                    check("ev_imm", imm_ext, e.imm);
                    if (!e.is_store) begin
                        check("ev_wb_sel", {30'd0, wb_sel}, {30'd0, e.wb_sel});
                        check("ev_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
                    end
                end
            end
        end
    end

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base = cyc;
    endtask

    task automatic at_cycle(input int k);
        @(negedge clk);
        while (cyc - base + 1 < k) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
        check({tag, "_dmem_re"}, {31'd0, dmem_re}, 32'd0);
        check({tag, "_dmem_we"}, {31'd0, dmem_we}, 32'd0);
        check({tag, "_mul_start"}, {31'd0, mul_start}, 32'd0);
    endtask

    initial begin
        int rf0, dw0, ms0;
        for (int i = 0; i < 16; i++) imem[i] = 32'h0;

        // Reset state.
        #12;
        check_idle_outputs("rst");
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // lw then add, zero-latency memory: lw write-back at cycle 5.
        imem[0] = I_LW; imem[1] = I_ADD3; mem_delay = 0;
        push_ev(1'b0, 2'b01, 5'd8, 5'd16, 5'd0, 32'h00000200, 32'd0, 16'd0, 5);
        push_ev(1'b0, 2'b00, 5'd3, 5'd1, 5'd2, 32'h00001020, 32'd4, 16'd1, 9);
        start_run();
        at_cycle(3);
        check("lw_exec_alu_imm", {31'd0, alu_src_imm}, 32'd1);
        at_cycle(4);
        check("lw_memrd_dmem_re", {31'd0, dmem_re}, 32'd1);
        at_cycle(6);
        check("lw_retired_after", {16'd0, retired}, 32'd1);
        check("lw_pc_after", imem_addr, 32'd4);
        at_cycle(8);
        check("add_exec_alu_imm", {31'd0, alu_src_imm}, 32'd0);
        at_cycle(10);
        check("a_halted", {31'd0, halted}, 32'd1);
        check("a_retired", {16'd0, retired}, 32'd2);
        check("a_pc", imem_addr, 32'd8);

        // Two adds restarted from HALT: halted after 8 cycles.
        imem[0] = I_ADD3; imem[1] = I_ADD4;
        push_ev(1'b0, 2'b00, 5'd3, 5'd1, 5'd2, 32'h00001020, 32'd0, 16'd0, 4);
        push_ev(1'b0, 2'b00, 5'd4, 5'd1, 5'd2, 32'h00001020, 32'd4, 16'd1, 8);
        start_run();
        at_cycle(1);
        check("b_restart_pc", imem_addr, 32'd0);
        check("b_restart_retired", {16'd0, retired}, 32'd0);
        check("b_busy", {31'd0, busy}, 32'd1);
        at_cycle(8);
        check("b_not_halted_c8", {31'd0, halted}, 32'd0);
        at_cycle(9);
        check("b_halted", {31'd0, halted}, 32'd1);
        check("b_retired", {16'd0, retired}, 32'd2);

        // mul with done 3 cycles after start, then sw with ready delayed 2 cycles.
        imem[0] = I_MUL; imem[1] = I_SW; mul_delay = 3; mem_delay = 2;
        push_ev(1'b0, 2'b10, 5'd14, 5'd8, 5'd9, 32'h00004818, 32'd0, 16'd0, 7);
        push_ev(1'b1, 2'b00, 5'd5, 5'd6, 5'd5, 32'hFFFFFFF0, 32'd4, 16'd1, 13);
        rf0 = rf_we_cnt; dw0 = dmem_we_cnt; ms0 = mul_start_cnt;
        start_run();
        at_cycle(3);
        check("c_mul_start_c3", {31'd0, mul_start}, 32'd1);
        check("c_mul_alu_imm", {31'd0, alu_src_imm}, 32'd0);
        at_cycle(4);
        check("c_mul_start_c4", {31'd0, mul_start}, 32'd0);
        start = 1'b1;
        at_cycle(5);
        start = 1'b0;
        at_cycle(10);
        check("c_sw_exec_alu_imm", {31'd0, alu_src_imm}, 32'd1);
        at_cycle(14);
        check("c_halted", {31'd0, halted}, 32'd1);
        check("c_pc", imem_addr, 32'd8);
        check("c_retired", {16'd0, retired}, 32'd2);
        check("c_mul_start_pulses", mul_start_cnt - ms0, 32'd1);
        check("c_dmem_we_cycles", dmem_we_cnt - dw0, 32'd3);
        check("c_rf_we_cycles", rf_we_cnt - rf0, 32'd1);

        // Illegal instruction at PC=4: sticky error, start and abort ignored.
        imem[0] = I_ADD3; imem[1] = I_BAD; mem_delay = 0; mul_delay = 0;
        push_ev(1'b0, 2'b00, 5'd3, 5'd1, 5'd2, 32'h00001020, 32'd0, 16'd0, 4);
        start_run();
        at_cycle(7);
        check("d_error", {31'd0, error}, 32'd1);
        check("d_pc_frozen", imem_addr, 32'd4);
        check("d_busy", {31'd0, busy}, 32'd0);
        check("d_retired", {16'd0, retired}, 32'd1);
        at_cycle(8);
        start = 1'b1;
        at_cycle(9);
        start = 1'b0;
        abort = 1'b1;
        at_cycle(10);
        abort = 1'b0;
        at_cycle(11);
        check("d_error_sticky", {31'd0, error}, 32'd1);
        check("d_pc_sticky", imem_addr, 32'd4);
        check_idle_outputs("d_err");
        rst_n = 1'b0;
        #2;
        check("d_rst_error", {31'd0, error}, 32'd0);
        check("d_rst_pc", imem_addr, 32'd0);
        check("d_rst_retired", {16'd0, retired}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort in MULW: PC and retired held, late mul_done ignored.
        imem[0] = I_ADD3; imem[1] = I_MUL; mul_delay = 6;
        push_ev(1'b0, 2'b00, 5'd3, 5'd1, 5'd2, 32'h00001020, 32'd0, 16'd0, 4);
        rf0 = rf_we_cnt;
        start_run();
        at_cycle(7);
        check("e_in_mulw", {31'd0, mul_start}, 32'd1);
        at_cycle(8);
        abort = 1'b1;
        at_cycle(9);
        abort = 1'b0;
        check_idle_outputs("e_abort");
        check("e_abort_pc", imem_addr, 32'd4);
        check("e_abort_retired", {16'd0, retired}, 32'd1);
        check("e_abort_halted", {31'd0, halted}, 32'd0);
        at_cycle(10);
        start = 1'b1;
        abort = 1'b1;
        at_cycle(11);
        start = 1'b0;
        abort = 1'b0;
        at_cycle(12);
        check("e_abort_beats_start", {31'd0, busy}, 32'd0);
        at_cycle(16);
        check("e_late_done_busy", {31'd0, busy}, 32'd0);
        check("e_rf_we_cycles", rf_we_cnt - rf0, 32'd1);

        // Restart, then asynchronous reset in the middle of FETCH.
        start_run();
        at_cycle(1);
        check("e_fetch_busy", {31'd0, busy}, 32'd1);
        check("e_fetch_retired", {16'd0, retired}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("e_rst");
        check("e_rst_pc", imem_addr, 32'd0);
        check("e_rst_retired", {16'd0, retired}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("e_after_rst_busy", {31'd0, busy}, 32'd0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
